// File: rtl/clock_pkg.sv
// Shared field widths, range limits and the 12-hour display mapping
// for the hh:mm:ss timekeeper.
package clock_pkg;

    localparam int HOUR_W = 5;
    localparam int MS_W   = 6;

    localparam logic [MS_W-1:0]   SEC_MAX  = 6'd59;
    localparam logic [MS_W-1:0]   MIN_MAX  = 6'd59;
    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

    // Midnight shows as 12, afternoon hours fold down by twelve.
    function automatic logic [HOUR_W-1:0] disp_hour12(input logic [HOUR_W-1:0] h);
        if (h == '0) begin
            return 5'd12;
        end else if (h > 5'd12) begin
            return h - 5'd12;
        end else begin
            return h;
        end
    endfunction

endpackage

// File: rtl/bin2bcd_2digit.sv
// Combinational binary (0..99) to two packed BCD digits {tens, units}.
module bin2bcd_2digit (
    input  logic [6:0] bin,
    output logic [7:0] bcd
);

    logic [6:0] tens;
    logic [6:0] units;

    always_comb begin
        tens  = bin / 7'd10;
        units = bin - (tens * 7'd10);
        bcd   = {4'(tens), 4'(units)};
    end

endmodule

// File: rtl/hms_timekeeper.sv
// Time-of-day core: prescaled 1 Hz tick, hh:mm:ss counters, load/set
// controls, 12/24-hour display with BCD outputs and an hh:mm alarm.
module hms_timekeeper
    import clock_pkg::*;
#(
    parameter int PRESCALE_DIV = 65536,
    parameter int HOUR_24      = 1,
    parameter int ALARM_EN     = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run_en,
    input  logic              load_en,
    input  logic [HOUR_W-1:0] load_hour,
    input  logic [MS_W-1:0]   load_min,
    input  logic [MS_W-1:0]   load_sec,
    input  logic              inc_min,
    input  logic              inc_hour,
    input  logic              alarm_en,
    input  logic [HOUR_W-1:0] alarm_hour,
    input  logic [MS_W-1:0]   alarm_min,
    output logic [HOUR_W-1:0] hour,
    output logic [MS_W-1:0]   minute,
    output logic [MS_W-1:0]   second,
    output logic [7:0]        hour_bcd,
    output logic [7:0]        min_bcd,
    output logic [7:0]        sec_bcd,
    output logic              pm,
    output logic              sec_tick,
    output logic              day_tick,
    output logic              alarm_hit,
    output logic              load_err
);

    localparam int              PS_W    = $clog2(PRESCALE_DIV);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE_DIV - 1);

    logic [PS_W-1:0]   ps_q;
    logic [HOUR_W-1:0] hour_q;
    logic [MS_W-1:0]   min_q;
    logic [MS_W-1:0]   sec_q;
    logic              sec_tick_q;
    logic              day_tick_q;
    logic              alarm_hit_q;
    logic              load_err_q;

    logic              tick;
    logic              load_ok;
    logic              sec_wrap;
    logic              min_wrap;
    logic              hour_wrap;
    logic [PS_W-1:0]   ps_adv;
    logic [MS_W-1:0]   sec_inc;
    logic [MS_W-1:0]   min_inc;
    logic [HOUR_W-1:0] hour_inc;
    logic [MS_W-1:0]   t_sec;
    logic [MS_W-1:0]   t_min;
    logic [HOUR_W-1:0] t_hour;
    logic              alarm_match;
    logic [HOUR_W-1:0] disp_hour;

    always_comb begin
        tick      = run_en && (ps_q == PS_LAST);
        ps_adv    = tick ? '0 : ps_q + PS_W'(1);
        load_ok   = (load_hour <= HOUR_MAX) && (load_min <= MIN_MAX) && (load_sec <= SEC_MAX);
        sec_wrap  = (sec_q == SEC_MAX);
        min_wrap  = (min_q == MIN_MAX);
        hour_wrap = (hour_q == HOUR_MAX);
        sec_inc   = sec_wrap  ? '0 : sec_q + 6'd1;
        min_inc   = min_wrap  ? '0 : min_q + 6'd1;
        hour_inc  = hour_wrap ? '0 : hour_q + 5'd1;
        // Time the tick would produce, used both for the update and the alarm compare.
        t_sec     = sec_inc;
        t_min     = sec_wrap ? min_inc : min_q;
        t_hour    = (sec_wrap && min_wrap) ? hour_inc : hour_q;
        alarm_match = (ALARM_EN != 0) && alarm_en
                   && (alarm_hour <= HOUR_MAX) && (alarm_min <= MIN_MAX)
                   && (t_sec == '0) && (t_min == alarm_min) && (t_hour == alarm_hour);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ps_q        <= '0;
            hour_q      <= '0;
            min_q       <= '0;
            sec_q       <= '0;
            sec_tick_q  <= 1'b0;
            day_tick_q  <= 1'b0;
            alarm_hit_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            sec_tick_q  <= 1'b0;
            day_tick_q  <= 1'b0;
            alarm_hit_q <= 1'b0;
            load_err_q  <= 1'b0;
            if (load_en) begin
                if (load_ok) begin
                    hour_q <= load_hour;
                    min_q  <= load_min;
                    sec_q  <= load_sec;
                    ps_q   <= '0;
                end else begin
                    load_err_q <= 1'b1;
                end
            end else if (inc_min || inc_hour) begin
                // Any tick landing here is swallowed; only inc_min restarts the second.
                if (inc_min) begin
                    min_q <= min_inc;
                    sec_q <= '0;
                    ps_q  <= '0;
                end else if (run_en) begin
                    ps_q <= ps_adv;
                end
                if (inc_hour) begin
                    hour_q <= hour_inc;
                end
            end else if (run_en) begin
                ps_q <= ps_adv;
                if (tick) begin
                    sec_q       <= t_sec;
                    min_q       <= t_min;
                    hour_q      <= t_hour;
                    sec_tick_q  <= 1'b1;
                    day_tick_q  <= sec_wrap && min_wrap && hour_wrap;
                    alarm_hit_q <= alarm_match;
                end
            end
        end
    end

    assign disp_hour = (HOUR_24 != 0) ? hour_q : disp_hour12(hour_q);
    assign pm        = (HOUR_24 == 0) && (hour_q >= 5'd12);

    bin2bcd_2digit u_hour_bcd (.bin({2'b00, disp_hour}), .bcd(hour_bcd));
    bin2bcd_2digit u_min_bcd  (.bin({1'b0, min_q}),      .bcd(min_bcd));
    bin2bcd_2digit u_sec_bcd  (.bin({1'b0, sec_q}),      .bcd(sec_bcd));

    assign hour      = hour_q;
    assign minute    = min_q;
    assign second    = sec_q;
    assign sec_tick  = sec_tick_q;
    assign day_tick  = day_tick_q;
    assign alarm_hit = alarm_hit_q;
    assign load_err  = load_err_q;

endmodule
